// File: rtl/alu_rr_sequencer.sv
// Two-requester round-robin sequencer for one shared combinational 4-bit ALU.
// Each accepted op runs IDLE -> EXEC (ALU settle) -> RESP (held until consumed).
module alu_rr_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [3:0]       req1_s,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  input  logic [5:0]       alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_y,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. reqN_ready is only ever high in IDLE; rsp_valid only in RESP.
  // Requesters hold a/b/s stable while valid is high and not yet accepted.

  logic [1:0] state;
  logic       last_grant;
  logic       op_id;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       rsp_fire;

  // On a tie, the requester that did not complete last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    rsp_fire   = (state == RESP) & rsp_valid & rsp_ready;
    busy       = (state != IDLE);
    fsm_state  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_s      <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_y      <= 6'd0;
      rsp_id     <= 1'b0;
      done0_cnt  <= '0;
      done1_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_id <= req1_ready;
            alu_a <= req1_ready ? req1_a : req0_a;
            alu_b <= req1_ready ? req1_b : req0_b;
            alu_s <= req1_ready ? req1_s : req0_s;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // alu_* are left untouched here so the ALU inputs stay stable under backpressure.
          if (rsp_fire) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            if (rsp_id) done1_cnt <= done1_cnt + CNT_W'(1);
            else        done0_cnt <= done0_cnt + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_rr_sequencer.md
# alu_rr_sequencer

Two-requester round-robin sequencer that shares the single 4-bit signed combinational ALU (16 ops, 6-bit result) between two clients. It sits between the two client datapaths and the ALU. It registers each accepted operation and drives the ALU operands from registers for one settle cycle. It then captures the 6-bit result and returns it on a single response channel tagged with the requester ID.

## Interface
Parameters:
- CNT_W, default 8: width of the per-requester completion counters.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  4  operands, two's complement
- req0_s / req1_s  in  4  ALU op select
- alu_a, alu_b  out  4  operands to the ALU
- alu_s  out  4  op select to the ALU
- alu_y  in  6  combinational ALU result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_y  out  6  captured result
- rsp_id  out  1  requester that issued the result
- busy  out  1  high in any state other than IDLE
- done0_cnt / done1_cnt  out  CNT_W  completed responses per requester, wrapping

## Operation
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant selection:
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - The granted reqN_ready is driven combinationally high in IDLE. The other ready is low.
- Handshake and capture:
  - On valid&ready, latch a, b, s and the ID into operand registers, then go to EXEC.
  - A request must hold its a, b and s stable until accepted.
  - No request is dropped. A losing requester keeps valid high and wins the next arbitration.
- EXEC:
  - alu_a, alu_b and alu_s are driven from the operand registers. They are registered outputs and stay stable from EXEC through RESP.
  - At the end of EXEC, alu_y is captured into rsp_y, then go to RESP.
- RESP:
  - rsp_valid is high.
  - rsp_y and rsp_id are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: set last_grant to rsp_id, increment done<rsp_id>_cnt (wraps to 0 after 2^CNT_W-1), then go to IDLE.
- Both reqN_ready outputs are low in EXEC and RESP.
- ALU result rules the bench checks against:
  - s = 0000..0111: signed arithmetic, sign-extended to 6 bits. The ops are a+1, a-1, a*2, b+1, b-1, b+b, a+b, a*4.
  - s = 1xxx: bitwise logic, zero-extended from 4 bits. The ops are ~a, ~b, a&b, a|b, a^b, ~(a^b), ~(a&b), ~(a|b).
- The sequencer never modifies alu_y.

## Timing
- Reset values (all asynchronous):
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - alu_a = alu_b = alu_s = 0.
  - rsp_valid = 0, rsp_y = 0, rsp_id = 0, busy = 0.
  - done0_cnt = done1_cnt = 0.
  - reqN_ready is combinational: it is 1 for a valid requester while in reset-released IDLE.
- Latency and throughput:
  - Accept at edge k. EXEC during cycle k+1. rsp_valid is high from cycle k+2.
  - With rsp_ready tied high, there is one op per 3 cycles and the next accept is possible in cycle k+3.
- Backpressure: while rsp_ready is low, state stays RESP and rsp_y, rsp_id and the alu_* outputs are unchanged.
- A response handshake in RESP and a new request in the same cycle: the new request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- Reset asserted mid-operation returns all state to the reset values immediately. The in-flight op is discarded with no response and no counter increment.
- Counter wrap: done0_cnt = 255 followed by one more completion gives 0 (CNT_W = 8).

## Test plan
- Single op, signed increment of max: req0 with a = 0111, s = 0000 -> rsp_y = 001000, rsp_id = 0, rsp_valid first high 2 cycles after accept.
- Signed decrement of min and a*4: req1 with a = 1000, s = 0001 -> rsp_y = 110111. Then req1 with a = 0110, s = 0111 -> rsp_y = 011000. Both have rsp_id = 1 and done1_cnt = 2.
- Logic op zero-extension: req0 with a = 0101, b = 0011, s = 1010 -> rsp_y = 000001. Then s = 1000 -> rsp_y = 001010.
- Contention after reset: both valid continuously with distinct ops -> grant order is 0, 1, 0, 1. Each rsp_id matches its op, and the loser's operands are never corrupted.
- Backpressure: hold rsp_ready low for 5 cycles in RESP -> rsp_y, rsp_id and alu_* are stable, both readies are low, and busy = 1. Raising rsp_ready completes the op in one cycle.
- Reset mid-EXEC: pulse rst_n low during EXEC -> all outputs go to their reset values asynchronously, no rsp_valid occurs, and the counters are 0.
